// File: rtl/shift_lfsr_engine_pkg.sv
// Shared types for the shift/LFSR engine: command opcodes, shift kinds, FSM states.
package shift_lfsr_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_SHIFT = 2'b01,
    OP_RUN   = 2'b10,
    OP_STOP  = 2'b11
  } op_e;

  // Encoding 2'b11 is not listed and behaves as a logical shift.
  typedef enum logic [1:0] {
    K_LOGIC = 2'b00,
    K_ARITH = 2'b01,
    K_ROT   = 2'b10
  } kind_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_RUN   = 2'b10
  } state_e;

endpackage

// File: rtl/shift_lfsr_engine_tick_divider.sv
// Free-running modulo-DIV counter producing a one-cycle enable pulse.
module tick_divider #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  assign tick = (r_cnt == LAST);

  // Count 0..DIV-1; clr restarts the period so the next tick is DIV cycles away.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/shift_lfsr_engine.sv
// Single-register engine: LOAD, staged barrel SHIFT (one power-of-two stage per
// cycle) and a divider-paced Fibonacci LFSR, all behind a valid/ready command port.
module shift_lfsr_engine
  import shift_lfsr_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'h1D),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(8'h01),
  parameter int               DIV   = 4,
  localparam int              SH_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [SH_W-1:0]  cmd_shamt,
  input  logic             cmd_lr,
  input  logic [1:0]       cmd_kind,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             running
);

  state_e           r_state, w_state_n;
  logic [WIDTH-1:0] r_q, w_q_n;
  logic             r_qv, w_qv_n;
  logic [SH_W-1:0]  r_stage, w_stage_n;
  logic [SH_W-1:0]  r_shamt;
  logic             r_lr;
  logic [1:0]       r_kind;
  logic             r_sign;
  logic             w_accept;
  logic             w_tick;
  op_e              w_op;

  // One shift stage by s positions; the arithmetic fill uses the sign captured at accept.
  function automatic logic [WIDTH-1:0] stage_shift(input logic [WIDTH-1:0] v,
                                                   input int unsigned s,
                                                   input logic lr,
                                                   input logic [1:0] kind,
                                                   input logic sign);
    logic [WIDTH-1:0] fill;
    fill = sign ? ~({WIDTH{1'b1}} >> s) : '0;
    if (kind == K_ROT) begin
      stage_shift = lr ? ((v << s) | (v >> (WIDTH - s))) : ((v >> s) | (v << (WIDTH - s)));
    end else if (lr) begin
      stage_shift = v << s;
    end else if (kind == K_ARITH) begin
      stage_shift = (v >> s) | fill;
    end else begin
      stage_shift = v >> s;
    end
  endfunction

  // Fibonacci step; the all-zero lock-up state is replaced by SEED.
  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] n;
    n = {^(v & TAPS), v[WIDTH-1:1]};
    lfsr_next = (n == '0) ? SEED : n;
  endfunction

  assign w_op      = op_e'(cmd_op);
  assign cmd_ready = (r_state != ST_SHIFT);
  assign w_accept  = cmd_valid && cmd_ready;
  assign q         = r_q;
  assign q_valid   = r_qv;
  assign running   = (r_state == ST_RUN);

  // Any accepted command restarts the step period, so a command always beats a due tick.
  tick_divider #(.DIV(DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_accept),
    .tick (w_tick)
  );

  // Next-state, next-q and q_valid decode.
  always_comb begin
    w_state_n = r_state;
    w_q_n     = r_q;
    w_qv_n    = 1'b0;
    w_stage_n = r_stage;
    case (r_state)
      ST_IDLE, ST_RUN: begin
        if (w_accept) begin
          case (w_op)
            OP_LOAD: begin
              w_q_n  = cmd_data;
              w_qv_n = 1'b1;
            end
            OP_SHIFT: begin
              w_state_n = ST_SHIFT;
              w_stage_n = '0;
            end
            OP_RUN: begin
              w_state_n = ST_RUN;
              if (r_q == '0) begin
                w_q_n  = SEED;
                w_qv_n = 1'b1;
              end
            end
            default: w_state_n = ST_IDLE;
          endcase
        end else if ((r_state == ST_RUN) && w_tick) begin
          w_q_n  = lfsr_next(r_q);
          w_qv_n = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (r_shamt[r_stage]) begin
          w_q_n = stage_shift(r_q, 32'd1 << r_stage, r_lr, r_kind, r_sign);
        end
        if (r_stage == SH_W'(SH_W - 1)) begin
          w_state_n = ST_IDLE;
          w_qv_n    = 1'b1;
        end else begin
          w_stage_n = r_stage + SH_W'(1);
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  // State, register value, pulse and stage counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_q     <= '0;
      r_qv    <= 1'b0;
      r_stage <= '0;
    end else begin
      r_state <= w_state_n;
      r_q     <= w_q_n;
      r_qv    <= w_qv_n;
      r_stage <= w_stage_n;
    end
  end

  // Capture shift parameters and the pre-shift sign at the accept edge.
  always_ff @(posedge clk) begin
    if (w_accept && (w_op == OP_SHIFT)) begin
      r_shamt <= cmd_shamt;
      r_lr    <= cmd_lr;
      r_kind  <= cmd_kind;
      r_sign  <= r_q[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_shift_lfsr_engine.sv
// Scoreboard bench for shift_lfsr_engine (WIDTH=8, TAPS=8'h1D, SEED=8'h01, DIV=4).
module tb_shift_lfsr_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic [2:0] cmd_shamt = 3'd0;
  logic       cmd_lr = 1'b0;
  logic [1:0] cmd_kind = 2'b00;
  logic [7:0] q;
  logic       q_valid;
  logic       running;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] sb[$];

  shift_lfsr_engine #(
    .WIDTH (8),
    .TAPS  (8'h1D),
    .SEED  (8'h01),
    .DIV   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_shamt (cmd_shamt),
    .cmd_lr    (cmd_lr),
    .cmd_kind  (cmd_kind),
    .q         (q),
    .q_valid   (q_valid),
    .running   (running)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_model(input logic [7:0] v);
    logic [7:0] n;
    n = {^(v & 8'h1D), v[7:1]};
    return (n == 8'h00) ? 8'h01 : n;
  endfunction

  // Every q_valid pulse must match the oldest expected value.
  always @(negedge clk) begin
    if (!rst && q_valid) begin
      if (sb.size() == 0) begin
        chk("qv_unexpected", 32'(q_valid), 32'd0);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        chk("q_on_valid", 32'(q), 32'(e));
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [7:0] d, input logic [2:0] sh,
                      input logic lr, input logic [1:0] k);
    @(negedge clk);
    chk("ready_at_send", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    cmd_shamt = sh;
    cmd_lr    = lr;
    cmd_kind  = k;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Posedges until q_valid is seen (sampled 1 after the edge); 99 on timeout.
  task automatic wait_pulse(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!q_valid && n < 20);
    if (!q_valid) begin
      chk("pulse_timeout", 32'(q_valid), 32'd1);
      n = 99;
    end
  endtask

  typedef struct {
    logic [7:0] d;
    logic [2:0] sh;
    logic       lr;
    logic [1:0] k;
    logic [7:0] exp;
  } shcase_t;

  shcase_t cases[9] = '{
    '{8'hB4, 3'd2, 1'b0, 2'b01, 8'hED},
    '{8'h81, 3'd3, 1'b1, 2'b10, 8'h0C},
    '{8'hFF, 3'd7, 1'b1, 2'b00, 8'h80},
    '{8'h5A, 3'd0, 1'b0, 2'b00, 8'h5A},
    '{8'h96, 3'd1, 1'b0, 2'b11, 8'h4B},
    '{8'hC3, 3'd2, 1'b1, 2'b01, 8'h0C},
    '{8'h81, 3'd1, 1'b0, 2'b10, 8'hC0},
    '{8'h94, 3'd5, 1'b0, 2'b01, 8'hFC},
    '{8'hA5, 3'd6, 1'b0, 2'b10, 8'h96}
  };

  initial begin
    int n;
    logic [7:0] v;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_qv", 32'(q_valid), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);

    // Shift table: LOAD then SHIFT, fixed three-cycle latency.
    foreach (cases[i]) begin
      sb.push_back(cases[i].d);
      send(2'b00, cases[i].d, 3'd0, 1'b0, 2'b00);
      sb.push_back(cases[i].exp);
      send(2'b01, 8'h00, cases[i].sh, cases[i].lr, cases[i].k);
      chk("shift_busy", 32'(cmd_ready), 32'd0);
      wait_pulse(n);
      chk("shift_latency", 32'(n), 32'd3);
      chk("shift_ready_after", 32'(cmd_ready), 32'd1);
    end

    // Full LFSR period from 8'h01.
    sb.push_back(8'h01);
    send(2'b00, 8'h01, 3'd0, 1'b0, 2'b00);
    v = 8'h01;
    for (int i = 0; i < 255; i++) begin
      v = lfsr_model(v);
      sb.push_back(v);
    end
    send(2'b10, 8'h00, 3'd0, 1'b0, 2'b00);
    chk("run_running", 32'(running), 32'd1);
    chk("run_no_seed_pulse", 32'(q_valid), 32'd0);
    for (int i = 0; i < 255; i++) begin
      wait_pulse(n);
      chk("run_step_gap", 32'(n), 32'd4);
    end
    chk("lfsr_period", 32'(q), 32'h01);
    send(2'b11, 8'h00, 3'd0, 1'b0, 2'b00);
    chk("stop_running", 32'(running), 32'd0);

    // RUN from zero seeds, then a LOAD landing on a due tick.
    sb.push_back(8'h00);
    send(2'b00, 8'h00, 3'd0, 1'b0, 2'b00);
    sb.push_back(8'h01);
    send(2'b10, 8'h00, 3'd0, 1'b0, 2'b00);
    chk("seed_pulse", 32'(q_valid), 32'd1);
    sb.push_back(lfsr_model(8'h01));
    wait_pulse(n);
    chk("seed_first_step", 32'(n), 32'd4);
    repeat (3) @(posedge clk);
    sb.push_back(8'h55);
    send(2'b00, 8'h55, 3'd0, 1'b0, 2'b00);
    chk("tick_load_pulse", 32'(q_valid), 32'd1);
    chk("tick_load_q", 32'(q), 32'h55);
    v = lfsr_model(8'h55);
    sb.push_back(v);
    wait_pulse(n);
    chk("step_after_load", 32'(n), 32'd4);
    chk("still_running", 32'(running), 32'd1);
    send(2'b11, 8'h00, 3'd0, 1'b0, 2'b00);
    chk("stop_mid_run", 32'(running), 32'd0);
    repeat (8) @(posedge clk);
    #1;
    chk("stop_q_frozen", 32'(q), 32'(v));

    // Back-to-back LOADs give consecutive pulses.
    sb.push_back(8'h3C);
    sb.push_back(8'hC3);
    send(2'b00, 8'h3C, 3'd0, 1'b0, 2'b00);
    send(2'b00, 8'hC3, 3'd0, 1'b0, 2'b00);
    chk("b2b_second_pulse", 32'(q_valid), 32'd1);

    // Reset during the second cycle of a SHIFT.
    sb.push_back(8'hA5);
    send(2'b00, 8'hA5, 3'd0, 1'b0, 2'b00);
    sb.push_back(8'h52);
    send(2'b01, 8'h00, 3'd1, 1'b0, 2'b00);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_q", 32'(q), 32'd0);
    chk("abort_qv", 32'(q_valid), 32'd0);
    chk("abort_running", 32'(running), 32'd0);
    chk("abort_ready", 32'(cmd_ready), 32'd1);
    rst = 1'b0;
    void'(sb.pop_back());
    repeat (6) @(posedge clk);
    #1;
    chk("abort_q_hold", 32'(q), 32'd0);

    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/shift_lfsr_engine.md
Name: shift_lfsr_engine

Overview:
- Parametrised successor to the 8-bit combinational shifter and clock-divided LFSR pair.
- Holds one WIDTH-bit register, driven through a valid/ready command port.
- Supports a multi-cycle staged barrel shift with logical, arithmetic and rotate modes, plus a free-running LFSR mode.
- The LFSR steps on a clock-enable tick from an internal divider, so no derived clock exists. The block sits between a host/test driver and display or pattern consumers.

Parameters:
- WIDTH, 8: register width; power of two, at least 4.
- TAPS, 8'h1D: LFSR feedback mask, Fibonacci form. Feedback is the XOR-reduce of (q & TAPS).
- SEED, 8'h01: nonzero value substituted when the LFSR would start or sit at zero.
- DIV, 4: clk cycles per LFSR step; at least 1.
- SH_W, $clog2(WIDTH): shift-amount width, derived; not overridden.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted on the edge where valid and ready are both high.
- cmd_op  in  2  00 LOAD, 01 SHIFT, 10 RUN, 11 STOP.
- cmd_data  in  WIDTH  LOAD value; ignored for other ops.
- cmd_shamt  in  SH_W  shift amount.
- cmd_lr  in  1  1 = left, 0 = right.
- cmd_kind  in  2  00 logical, 01 arithmetic, 10 rotate, 11 treated as logical.
- q  out  WIDTH  register value.
- q_valid  out  1  one-cycle pulse whenever q takes a final new value.
- running  out  1  high in the RUN state.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port rst.
- Reset values: q = 0, q_valid = 0, running = 0, state = IDLE, divider count = 0, cmd_ready = 1 in the cycle after reset. rst has priority over every other event.
- States:
  - IDLE: cmd_ready = 1.
  - SHIFT: cmd_ready = 0.
  - RUN: cmd_ready = 1, running = 1.
- LOAD
  - From IDLE: q <= cmd_data; q_valid pulses next cycle; stay in IDLE.
  - From RUN: same update, stay in RUN, divider count cleared.
- SHIFT (from IDLE or RUN)
  - Latch shamt, lr and kind at the accept edge E0, then enter SHIFT.
  - At edge Ek (k = 1..SH_W), stage k-1 shifts q by 2^(k-1) if shamt bit k-1 is set; otherwise q is held.
  - After E_SH_W: state = IDLE, q_valid = 1 for one cycle, cmd_ready = 1. Latency is SH_W cycles, fixed regardless of shamt.
  - q is not meaningful during SHIFT.
- Shift rules:
  - Logical: zero fill.
  - Arithmetic right: fills with the original MSB, sign held across all stages.
  - Arithmetic left: identical to logical left.
  - Rotate: bits wrap; rotate by 0 leaves q unchanged.
  - shamt = 0 still takes SH_W cycles and pulses q_valid.
- RUN
  - Enter RUN and clear the divider. If q == 0 at accept, q <= SEED and q_valid pulses.
  - Divider counts 0..DIV-1 and ticks when count == DIV-1; the first step occurs DIV cycles after accept.
  - Tick: q <= {fb, q[WIDTH-1:1]}, where fb = ^(q & TAPS); q_valid pulses.
  - If a step would yield 0 (possible only with a non-maximal TAPS), q <= SEED instead.
  - RUN accepted while already in RUN: restarts the divider.
- STOP: RUN -> IDLE, q held; in IDLE it is a no-op.
- Simultaneous events: an accepted command and a divider tick on the same edge: the command wins, the step is discarded, and the divider clears.
- Reset mid-operation: reset in SHIFT or RUN aborts to reset values; the partial shift is lost.
- q_valid: never high for two consecutive cycles from a single event. Back-to-back LOADs give consecutive pulses.

Decomposition:
- Package shift_lfsr_pkg:
  - op_e enum: LOAD, SHIFT, RUN, STOP.
  - kind_e enum: LOGIC, ARITH, ROT.
  - state_e enum: IDLE, SHIFT, RUN.
- Sub-module tick_divider (parameter DIV, inputs clk, rst, clr; output tick): counter with a single-cycle enable pulse, reused elsewhere for slow displays.
- Shift stage logic stays inline.

Test Plan (WIDTH = 8, TAPS = 8'h1D, SEED = 8'h01, DIV = 4):
- Reset, then LOAD 8'hB4, then SHIFT right arith shamt = 2 -> cmd_ready low for 3 cycles; q = 8'hED with a q_valid pulse.
- LOAD 8'h81, then SHIFT left rotate shamt = 3 -> q = 8'h0C. LOAD 8'hFF, then SHIFT left logical shamt = 7 -> q = 8'h80.
- LOAD 8'h01, then RUN -> q = 8'h80 four cycles after accept, 8'h40 after eight. q returns to 8'h01 after exactly 255 steps. q_valid pulses every 4th cycle.
- LOAD 8'h00, then RUN -> q = 8'h01 with a q_valid pulse the cycle after accept. STOP mid-run -> q frozen, running = 0.
- Issue LOAD 8'h55 in RUN on the edge where a tick is due -> q = 8'h55, no step applied; the next step comes 4 cycles later.
- Assert rst during cycle 2 of a SHIFT -> next cycle q = 0, q_valid = 0, running = 0, cmd_ready = 1; no stale q_valid pulse.
